// File: rtl/ram_loader_arbiter.sv
// Serial monitor and RAM/UART arbiter between the host UART, the CPU and program RAM.
// Monitor parses 'L' (load), 'R' (read back) and 'X' (run) host commands.
// While running, RAM and UART ports pass through to the CPU until cpu_halted.
// Ports: clk, rst (async active-low), UART rx/tx, RAM rd/wr, CPU side, running.
// Build option: LOADER_CHECKSUM_EN makes the 'L' ack the mod-256 data byte sum.
module ram_loader_arbiter #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_received,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  tx_transmit,
    input  logic [7:0]            ram_dread,
    output logic [addr_width-1:0] ram_raddr,
    output logic [addr_width-1:0] ram_waddr,
    output logic [7:0]            ram_dwrite,
    output logic                  ram_write_en,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic [7:0]            cpu_dwrite,
    input  logic                  cpu_write_en,
    input  logic [7:0]            cpu_tx_byte,
    input  logic                  cpu_transmit,
    input  logic                  cpu_halted,
    output logic                  cpu_received,
    output logic [7:0]            cpu_rx_byte,
    output logic                  cpu_is_transmitting,
    output logic                  cpu_rst,
    output logic [addr_width-1:0] cpu_startaddr,
    output logic                  running
);
    localparam int AW = addr_width;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_X = 8'h58;
    localparam logic [7:0] CH_Q = 8'h3F;
    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_DOT = 8'h2E;

    typedef enum logic [3:0] {
        IDLE, ADDRH, ADDRL, LEN, LOAD, RDREQ,
        RDWAIT, RDSEND, TXWAIT, RUN, ACK
    } state_t;

    state_t          state_q, state_d;
    logic            running_q, running_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [8:0]      count_q, count_d;
    logic [7:0]      ack_q, ack_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_go_q, tx_go_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [7:0]      dwrite_q, dwrite_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic [AW-1:0]   start_q, start_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        count_d   = count_q;
        ack_d     = ack_q;
        tx_byte_d = tx_byte_q;
        tx_go_d   = 1'b0;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        dwrite_d  = dwrite_q;
        // Read address trails addr by a cycle; it is settled by RDREQ.
        raddr_d   = addr_q;
        cpu_rst_d = 1'b0;
        start_d   = start_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_received) begin
                    cmd_d = rx_byte;
                    if (rx_byte == CH_L || rx_byte == CH_R ||
                        rx_byte == CH_X) begin
                        state_d = ADDRH;
                    end else begin
                        ack_d   = CH_Q;
                        state_d = ACK;
                    end
                end
            end
            ADDRH: begin
                if (rx_received) begin
                    addr_d  = {rx_byte[AW-9:0], addr_q[7:0]};
                    state_d = ADDRL;
                end
            end
            ADDRL: begin
                if (rx_received) begin
                    addr_d = {addr_q[AW-1:8], rx_byte};
                    if (cmd_q == CH_X) begin
                        start_d   = {addr_q[AW-1:8], rx_byte};
                        cpu_rst_d = 1'b1;
                        running_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (rx_received) begin
                    count_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
`ifdef LOADER_CHECKSUM_EN
                    sum_d = 8'd0;
`endif
                    state_d = (cmd_q == CH_L) ? LOAD : RDREQ;
                end
            end
            LOAD: begin
                if (rx_received) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    dwrite_d = rx_byte;
                    addr_d   = addr_q + ADDR_ONE;
                    count_d  = count_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_byte;
                    ack_d = sum_q + rx_byte;
`else
                    ack_d = CH_DOT;
`endif
                    if (count_q == 9'd1) state_d = ACK;
                end
            end
            RDREQ:  state_d = RDWAIT;
            RDWAIT: state_d = RDSEND;
            RDSEND: begin
                if (!tx_is_transmitting) begin
                    tx_go_d   = 1'b1;
                    tx_byte_d = ram_dread;
                    addr_d    = addr_q + ADDR_ONE;
                    count_d   = count_q - 9'd1;
                    state_d   = TXWAIT;
                end
            end
            TXWAIT: begin
                // One dead cycle so the UART busy flag can rise.
                if (cmd_q == CH_R && count_q != 9'd0) state_d = RDREQ;
                else state_d = IDLE;
            end
            RUN: begin
                if (cpu_halted) begin
                    running_d = 1'b0;
                    ack_d     = CH_H;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!tx_is_transmitting) begin
                    tx_go_d   = 1'b1;
                    tx_byte_d = ack_q;
                    state_d   = TXWAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            cmd_q     <= 8'd0;
            addr_q    <= '0;
            count_q   <= 9'd0;
            ack_q     <= 8'd0;
            tx_byte_q <= 8'd0;
            tx_go_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            dwrite_q  <= 8'd0;
            raddr_q   <= '0;
            cpu_rst_q <= 1'b0;
            start_q   <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            tx_byte_q <= tx_byte_d;
            tx_go_q   <= tx_go_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            dwrite_q  <= dwrite_d;
            raddr_q   <= raddr_d;
            cpu_rst_q <= cpu_rst_d;
            start_q   <= start_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sum_q <= 8'd0;
        else      sum_q <= sum_d;
    end
`endif

    assign ram_raddr    = running_q ? cpu_raddr    : raddr_q;
    assign ram_waddr    = running_q ? cpu_waddr    : waddr_q;
    assign ram_dwrite   = running_q ? cpu_dwrite   : dwrite_q;
    assign ram_write_en = running_q ? cpu_write_en : we_q;
    assign tx_byte      = running_q ? cpu_tx_byte  : tx_byte_q;
    assign tx_transmit  = running_q ? cpu_transmit : tx_go_q;

    assign cpu_received        = running_q & rx_received;
    assign cpu_rx_byte         = rx_byte;
    assign cpu_is_transmitting = running_q ? tx_is_transmitting : 1'b1;
    assign cpu_rst             = cpu_rst_q;
    assign cpu_startaddr       = start_q;
    assign running             = running_q;
endmodule
